mux8_serial_feeder: RTL and testbench

- Upstream stage for the 8:1 bit-select mux.
- Accepts parallel words over a valid/ready handshake, holds each word stable on the mux data lines, and steps the 3-bit select through every bit position, one position per accepted beat.
- Downstream, the mux output together with bit_valid/bit_last forms a serial bitstream.
- Supports LSB-first or MSB-first order per word, back-to-back words with no bubble, a synchronous flush, and a completed-word counter.

---
 rtl/mux8_serial_feeder.sv | 107 ++++++++++
 tb/tb_mux8_serial_feeder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux8_serial_feeder.sv
// Parallel-to-serial front end for an 8:1 bit-select mux: holds each accepted
// word on mux_i and walks mux_s across every bit, LSB- or MSB-first per word.
module mux8_serial_feeder #(
  parameter int SEL_W = 3,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2**SEL_W-1:0]   in_data,
  input  logic                  in_msb_first,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [2**SEL_W-1:0]   mux_i,
  output logic [SEL_W-1:0]      mux_s,
  output logic                  bit_valid,
  input  logic                  bit_ready,
  output logic                  bit_last,
  output logic [CNT_W-1:0]      words_done
);

  localparam int DATA_W = 2**SEL_W;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state, state_n;
  logic [DATA_W-1:0]   data_q, data_n;
  logic [SEL_W-1:0]    sel_q, sel_n;
  logic                msb_q, msb_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;

  logic                in_shift;
  logic                last_bit;
  logic                word_end;
  logic                accept;
  logic [SEL_W-1:0]    last_idx;

  // Starting index for a word given its bit order.
  function automatic logic [SEL_W-1:0] first_idx(input logic msb_first);
    return msb_first ? {SEL_W{1'b1}} : {SEL_W{1'b0}};
  endfunction

  // One step toward the final index; never wraps because the word ends first.
  function automatic logic [SEL_W-1:0] step_idx(input logic [SEL_W-1:0] idx,
                                                input logic msb_first);
    return msb_first ? idx - SEL_W'(1) : idx + SEL_W'(1);
  endfunction

  assign in_shift = (state == SHIFT);
  assign last_idx = msb_q ? {SEL_W{1'b0}} : {SEL_W{1'b1}};
  assign last_bit = in_shift && (sel_q == last_idx);
  assign word_end = last_bit && bit_ready;
  assign in_ready = !flush && (!in_shift || word_end);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_n = state;
    data_n  = data_q;
    sel_n   = sel_q;
    msb_n   = msb_q;
    cnt_n   = cnt_q;
    if (flush) begin
      state_n = IDLE;
      sel_n   = '0;
    end else begin
      if (word_end) begin
        cnt_n   = cnt_q + CNT_W'(1);
        state_n = IDLE;
      end else if (in_shift && bit_ready) begin
        sel_n = step_idx(sel_q, msb_q);
      end
      // Accept overrides the IDLE return so back-to-back words have no bubble.
      if (accept) begin
        data_n  = in_data;
        msb_n   = in_msb_first;
        sel_n   = first_idx(in_msb_first);
        state_n = SHIFT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      data_q <= '0;
      sel_q  <= '0;
      msb_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      state  <= state_n;
      data_q <= data_n;
      sel_q  <= sel_n;
      msb_q  <= msb_n;
      cnt_q  <= cnt_n;
    end
  end

  assign mux_i      = data_q;
  assign mux_s      = sel_q;
  assign bit_valid  = in_shift;
  assign bit_last   = last_bit;
  assign words_done = cnt_q;

endmodule

// File: tb/tb_mux8_serial_feeder.sv
// Directed bench for mux8_serial_feeder; expected bits come from a queue
// filled when each word is offered and drained as the DUT presents bits.
module tb_mux8_serial_feeder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_msb_first;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  logic [7:0] mux_i;
  logic [2:0] mux_s;
  logic       bit_valid;
  logic       bit_ready;
  logic       bit_last;
  logic [7:0] words_done;

  typedef struct packed {
    logic [2:0] sel;
    logic       b;
    logic       last;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   shift_cycles = 0;
  int   exp_done = 0;

  mux8_serial_feeder #(.SEL_W(3), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_msb_first(in_msb_first),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush), .mux_i(mux_i),
    .mux_s(mux_s), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .bit_last(bit_last), .words_done(words_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] d, input logic msb);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.sel  = msb ? 3'(7 - i) : 3'(i);
      e.b    = d[e.sel];
      e.last = (i == 7);
      q.push_back(e);
    end
  endtask

  // Check the presented bit at the falling edge, then advance one clock.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (bit_valid) shift_cycles++;
    if (bit_valid && bit_ready) begin
      if (q.size() == 0) chk("sb_extra_bit", bit_valid, 0);
      else begin
        e = q.pop_front();
        chk("bit_sel", mux_s, e.sel);
        chk("bit_val", mux_i[mux_s], e.b);
        chk("bit_last", bit_last, e.last);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((bit_valid || q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_left", q.size(), 0);
    chk("drain_valid", bit_valid, 0);
  endtask

  task automatic offer(input logic [7:0] d, input logic msb);
    in_data = d;
    in_msb_first = msb;
    in_valid = 1'b1;
    push_word(d, msb);
  endtask

  initial begin
    bit [7:0] d;
    bit       m;
    bit       acc;
    int       n;
    rst_n = 1'b0; in_data = '0; in_msb_first = 1'b0; in_valid = 1'b0;
    flush = 1'b0; bit_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", bit_valid, 0);
    chk("rst_sel", mux_s, 0);
    chk("rst_data", mux_i, 0);
    chk("rst_done", words_done, 0);
    chk("rst_ready", in_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // LSB-first 0xA5
    offer(8'hA5, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("lsb_first_sel", mux_s, 0);
    drain(20);
    exp_done++;
    chk("lsb_done", words_done, exp_done);
    chk("lsb_idle_ready", in_ready, 1);

    // MSB-first 0x3C
    offer(8'h3C, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("msb_first_sel", mux_s, 7);
    drain(20);
    exp_done++;
    chk("msb_done", words_done, exp_done);

    // Back-to-back 0x01 LSB then 0x80 MSB
    offer(8'h01, 1'b0);
    tick();
    offer(8'h80, 1'b1);
    shift_cycles = 0;
    for (int i = 0; i < 16; i++) begin
      chk("b2b_ready", in_ready, (i == 7 || i == 15) ? 1 : 0);
      chk("b2b_valid", bit_valid, 1);
      tick();
      if (i == 7) in_valid = 1'b0;
    end
    chk("b2b_cycles", shift_cycles, 16);
    chk("b2b_idle", bit_valid, 0);
    exp_done += 2;
    chk("b2b_done", words_done, exp_done);

    // Backpressure at mux_s=4 of 0xF0
    offer(8'hF0, 1'b0);
    tick();
    in_valid = 1'b0;
    shift_cycles = 0;
    repeat (4) tick();
    chk("bp_at4", mux_s, 4);
    bit_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_sel", mux_s, 4);
      chk("bp_hold_data", mux_i, 8'hF0);
      chk("bp_hold_valid", bit_valid, 1);
    end
    bit_ready = 1'b1;
    drain(20);
    chk("bp_cycles", shift_cycles, 11);
    exp_done++;
    chk("bp_done", words_done, exp_done);

    // Flush at mux_s=3 with a concurrent offer
    offer(8'h5A, 1'b0);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("fl_at3", mux_s, 3);
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hFF;
    chk("fl_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    q.delete();
    chk("fl_valid", bit_valid, 0);
    chk("fl_sel", mux_s, 0);
    chk("fl_data", mux_i, 8'h5A);
    chk("fl_done", words_done, exp_done);
    tick();
    chk("fl_still_idle", bit_valid, 0);

    // Async reset while mux_s=5
    offer(8'h33, 1'b0);
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    chk("ar_at5", mux_s, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", bit_valid, 0);
    chk("ar_sel", mux_s, 0);
    chk("ar_data", mux_i, 0);
    chk("ar_done", words_done, 0);
    chk("ar_last", bit_last, 0);
    q.delete();
    exp_done = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ar_resume_idle", bit_valid, 0);

    // 256 continuous words: counter wraps to 0
    for (int w = 0; w < 256; w++) begin
      d = 8'($urandom);
      m = 1'($urandom);
      offer(d, m);
      n = 0;
      acc = 1'b0;
      while (!acc && n < 20) begin
        acc = in_ready && in_valid;
        tick();
        n++;
      end
      chk("wrap_accept", acc, 1);
    end
    in_valid = 1'b0;
    drain(40);
    chk("wrap_done", words_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
